// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : Execute-to-memory-stage bundle plus the MEM/WB result bus.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if #(
    parameter int PC_SIZE = 10
);
    logic               stall;
    logic               flush;
    logic [PC_SIZE-1:0] PC_jump;
    logic               zero;
    logic [7:0]         ALU_result;
    logic [7:0]         store_data;
    logic [4:0]         rd_in;
    logic               reg_write_in;
    logic               branch_in;
    logic               mem_read_in;
    logic               mem_to_reg_in;
    logic               mem_write_in;
    logic               PC_src;
    logic [PC_SIZE-1:0] PC_branch;
    logic [7:0]         wb_data;
    logic [4:0]         rd_out;
    logic               reg_write_out;
    logic               valid_out;

    modport master (
        output stall, flush, PC_jump, zero, ALU_result, store_data, rd_in,
               reg_write_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in,
        input  PC_src, PC_branch, wb_data, rd_out, reg_write_out, valid_out
    );

    modport slave (
        input  stall, flush, PC_jump, zero, ALU_result, store_data, rd_in,
               reg_write_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in,
        output PC_src, PC_branch, wb_data, rd_out, reg_write_out, valid_out
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : EX/MEM register, branch resolution, data memory, MEM/WB register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int PC_SIZE = 10,
    parameter int ADDR_W  = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mem_stage_if.slave  bus
);
    localparam int c_DEPTH = 1 << ADDR_W;

    // EX/MEM pipeline register
    logic [PC_SIZE-1:0] r_pc_jump;
    logic               r_zero;
    logic [7:0]         r_alu;
    logic [7:0]         r_store_data;
    logic [4:0]         r_rd;
    logic               r_reg_write;
    logic               r_branch;
    logic               r_mem_read;
    logic               r_mem_to_reg;
    logic               r_mem_write;
    logic               r_valid;

    // MEM/WB pipeline register
    logic [7:0]         r_wb_data;
    logic [4:0]         r_rd_out;
    logic               r_reg_write_out;
    logic               r_valid_out;

    logic [7:0]         r_mem [c_DEPTH];

    logic [ADDR_W-1:0]  w_addr;
    logic               w_mem_we;
    logic [7:0]         w_load_data;
    logic [7:0]         w_wb_next;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_pc_jump    <= '0;
            r_zero       <= 1'b0;
            r_alu        <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_branch     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_write  <= 1'b0;
            r_valid      <= 1'b0;
        end else if (!bus.stall) begin
            r_pc_jump    <= bus.PC_jump;
            r_zero       <= bus.zero;
            r_alu        <= bus.ALU_result;
            r_store_data <= bus.store_data;
            r_rd         <= bus.rd_in;
            r_reg_write  <= bus.reg_write_in;
            r_branch     <= bus.branch_in;
            r_mem_read   <= bus.mem_read_in;
            r_mem_to_reg <= bus.mem_to_reg_in;
            r_mem_write  <= bus.mem_write_in;
            r_valid      <= 1'b1;
        end
    end

    // Only the low address bits index the memory, so addresses wrap.
    assign w_addr      = r_alu[ADDR_W-1:0];
    assign w_mem_we    = r_mem_write & ~bus.stall & ~rst;
    assign w_load_data = r_mem_read ? r_mem[w_addr] : 8'h00;
    assign w_wb_next   = r_mem_to_reg ? w_load_data : r_alu;

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_addr] <= r_store_data;
        end
    end

    // A stalled instruction must not reach write-back twice, so emit a bubble.
    always_ff @(posedge clk) begin
        if (rst || bus.stall) begin
            r_wb_data       <= '0;
            r_rd_out        <= '0;
            r_reg_write_out <= 1'b0;
            r_valid_out     <= 1'b0;
        end else begin
            r_wb_data       <= w_wb_next;
            r_rd_out        <= r_rd;
            r_reg_write_out <= r_reg_write;
            r_valid_out     <= r_valid;
        end
    end

    assign bus.PC_src        = r_branch & r_zero & ~bus.stall;
    assign bus.PC_branch     = r_pc_jump;
    assign bus.wb_data       = r_wb_data;
    assign bus.rd_out        = r_rd_out;
    assign bus.reg_write_out = r_reg_write_out;
    assign bus.valid_out     = r_valid_out;
endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Scoreboard bench for mem_stage (reference memory + EX/MEM model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    localparam int c_PC = 10;

    typedef struct {
        logic [7:0] wb;
        logic [4:0] rd;
        logic       rw;
    } wb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_stage_if #(.PC_SIZE(c_PC)) bus ();

    mem_stage #(.PC_SIZE(c_PC), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    wb_t        exp_q[$];
    logic [7:0] mdl_mem [256];
    logic [c_PC-1:0] m_pcj;
    logic       m_z, m_rw, m_br, m_mr, m_m2r, m_mw, m_valid;
    logic [7:0] m_alu, m_sd;
    logic [4:0] m_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [7:0] alu, input logic [7:0] sd, input logic [4:0] rd,
                          input logic rw, input logic br, input logic mr, input logic m2r,
                          input logic mw, input logic [c_PC-1:0] pcj, input logic z);
        bus.ALU_result    = alu;
        bus.store_data    = sd;
        bus.rd_in         = rd;
        bus.reg_write_in  = rw;
        bus.branch_in     = br;
        bus.mem_read_in   = mr;
        bus.mem_to_reg_in = m2r;
        bus.mem_write_in  = mw;
        bus.PC_jump       = pcj;
        bus.zero          = z;
    endtask

    task automatic nop();
        set_in(8'h00, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // Advance one clock: update reference model with the values the DUT sees, then check.
    task automatic tick();
        wb_t e;
        if (!rst && !bus.stall && m_valid) begin
            e.wb = m_m2r ? (m_mr ? mdl_mem[m_alu] : 8'h00) : m_alu;
            e.rd = m_rd;
            e.rw = m_rw;
            exp_q.push_back(e);
            if (m_mw) mdl_mem[m_alu] = m_sd;
        end
        if (rst || bus.flush) begin
            {m_z, m_rw, m_br, m_mr, m_m2r, m_mw, m_valid} = '0;
            m_pcj = '0;
        end else if (!bus.stall) begin
            m_pcj = bus.PC_jump;  m_z = bus.zero;  m_alu = bus.ALU_result;
            m_sd = bus.store_data; m_rd = bus.rd_in; m_rw = bus.reg_write_in;
            m_br = bus.branch_in; m_mr = bus.mem_read_in; m_m2r = bus.mem_to_reg_in;
            m_mw = bus.mem_write_in; m_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        check("valid_out", {31'd0, bus.valid_out}, {31'd0, exp_q.size() > 0});
        if (bus.valid_out && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wb_data", {24'd0, bus.wb_data}, {24'd0, e.wb});
            check("rd_out", {27'd0, bus.rd_out}, {27'd0, e.rd});
            check("reg_write_out", {31'd0, bus.reg_write_out}, {31'd0, e.rw});
        end else if (!bus.valid_out) begin
            check("bubble_reg_write", {31'd0, bus.reg_write_out}, 32'd0);
        end
        check("PC_src", {31'd0, bus.PC_src}, {31'd0, m_br & m_z & ~bus.stall});
        if (m_br) check("PC_branch", {22'd0, bus.PC_branch}, {22'd0, m_pcj});
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        nop();
        {m_z, m_rw, m_br, m_mr, m_m2r, m_mw, m_valid} = '0;
        m_pcj = '0; m_alu = '0; m_sd = '0; m_rd = '0;

        // Reset with random inputs and a pending store
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_in(8'($urandom), 8'($urandom), 5'($urandom), 1'b1, 1'b1,
                   1'b0, 1'b0, 1'b1, c_PC'($urandom), 1'b1);
            tick();
        end
        check("rst_PC_src", {31'd0, bus.PC_src}, 32'd0);
        check("rst_PC_branch", {22'd0, bus.PC_branch}, 32'd0);
        check("rst_wb_data", {24'd0, bus.wb_data}, 32'd0);
        check("rst_rd_out", {27'd0, bus.rd_out}, 32'd0);
        check("rst_reg_write", {31'd0, bus.reg_write_out}, 32'd0);
        check("rst_valid", {31'd0, bus.valid_out}, 32'd0);
        rst = 1'b0;
        nop();
        tick();

        // ALU pass-through
        set_in(8'h5A, 8'h00, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        nop();
        tick();
        check("pass_wb", {24'd0, bus.wb_data}, 32'h5A);
        check("pass_rd", {27'd0, bus.rd_out}, 32'd7);
        check("pass_valid", {31'd0, bus.valid_out}, 32'd1);

        // Store then load, normal and wrap-boundary address
        set_in(8'h10, 8'hC3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0); tick();
        set_in(8'h10, 8'h00, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0); tick();
        nop(); tick();
        check("load_10", {24'd0, bus.wb_data}, 32'hC3);
        set_in(8'hFF, 8'h01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0); tick();
        set_in(8'hFF, 8'h00, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0); tick();
        nop(); tick();
        check("load_FF", {24'd0, bus.wb_data}, 32'h01);

        // Branch taken / not taken
        set_in(8'h00, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h2A4, 1'b1); tick();
        check("br_taken", {31'd0, bus.PC_src}, 32'd1);
        check("br_target", {22'd0, bus.PC_branch}, 32'h2A4);
        set_in(8'h00, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h155, 1'b0); tick();
        check("br_not_taken", {31'd0, bus.PC_src}, 32'd0);

        // Store held by a 3-cycle stall, then reloaded
        set_in(8'h20, 8'h77, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h0F0, 1'b1); tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(8'h20, 8'h99, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'h3FF, 1'b1);
            tick();
            check("stall_PC_src", {31'd0, bus.PC_src}, 32'd0);
            check("stall_valid", {31'd0, bus.valid_out}, 32'd0);
        end
        bus.stall = 1'b0;
        set_in(8'h20, 8'h00, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0); tick();
        nop(); tick();
        check("stall_load_20", {24'd0, bus.wb_data}, 32'h77);

        // Flush turns a branch/write instruction into a bubble
        bus.flush = 1'b1;
        set_in(8'h33, 8'h00, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h111, 1'b1); tick();
        check("flush_PC_src", {31'd0, bus.PC_src}, 32'd0);
        bus.flush = 1'b0;
        nop(); tick();
        check("flush_reg_write", {31'd0, bus.reg_write_out}, 32'd0);
        check("flush_valid", {31'd0, bus.valid_out}, 32'd0);

        // Reset discards a pending store; memory keeps its old value
        set_in(8'h40, 8'h11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0); tick();
        set_in(8'h40, 8'hEE, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0); tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        set_in(8'h40, 8'h00, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0); tick();
        nop(); tick();
        check("rst_keeps_mem", {24'd0, bus.wb_data}, 32'h11);

        nop(); tick();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
